wb_stage: RTL and testbench

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_stage.sv | 162 ++++++++++++++++
 tb/tb_wb_stage.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Write-back stage: holds one retiring instruction, waits for load data when needed,
// and formats the register-file write (byte/half extension, LWL/LWR merge strobes).
//
// state   | meaning
// --------+--------------------------------------------------
// S_EMPTY | no instruction held
// S_WAIT  | load held, response word not yet received
// S_READY | instruction complete, register write presented
module wb_stage (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ms_to_ws_valid,
  output logic        ws_allowin,
  input  logic [31:0] ms_pc,
  input  logic [4:0]  ms_dest,
  input  logic        ms_gr_we,
  input  logic        ms_need_data,
  input  logic [2:0]  ms_load_op,
  input  logic [1:0]  ms_addr_lo,
  input  logic [31:0] ms_result,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic        rf_wen,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [3:0]  rf_strb,
  output logic [4:0]  ws_dest,
  output logic        ws_pending,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_wen,
  output logic [4:0]  debug_wb_rf_wnum
);

  typedef enum logic [1:0] {S_EMPTY, S_WAIT, S_READY} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [4:0]  dest_q, dest_d;
  logic        gr_we_q, gr_we_d;
  logic [2:0]  load_op_q, load_op_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [31:0] result_q, result_d;
  logic [31:0] rdata_q, rdata_d;

  logic        entry;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] wdata_dec;
  logic [3:0]  strb_dec;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_EMPTY;
      pc_q      <= '0;
      dest_q    <= '0;
      gr_we_q   <= 1'b0;
      load_op_q <= '0;
      addr_lo_q <= '0;
      result_q  <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      dest_q    <= dest_d;
      gr_we_q   <= gr_we_d;
      load_op_q <= load_op_d;
      addr_lo_q <= addr_lo_d;
      result_q  <= result_d;
      rdata_q   <= rdata_d;
    end
  end

  assign ws_allowin = (state_q == S_EMPTY) || (state_q == S_READY);
  assign entry      = ms_to_ws_valid && ws_allowin;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    dest_d    = dest_q;
    gr_we_d   = gr_we_q;
    load_op_d = load_op_q;
    addr_lo_d = addr_lo_q;
    result_d  = result_q;
    rdata_d   = rdata_q;
    if (state_q == S_WAIT) begin
      if (data_data_ok) begin
        rdata_d = data_rdata;
        state_d = S_READY;
      end
    end else if (entry) begin
      pc_d      = ms_pc;
      dest_d    = ms_dest;
      gr_we_d   = ms_gr_we;
      load_op_d = ms_load_op;
      addr_lo_d = ms_addr_lo;
      result_d  = ms_result;
      // A response arriving on the entry edge completes the load immediately.
      if (ms_need_data && data_data_ok) begin
        rdata_d = data_rdata;
        state_d = S_READY;
      end else if (ms_need_data) begin
        state_d = S_WAIT;
      end else begin
        state_d = S_READY;
      end
    end else if (state_q == S_READY) begin
      state_d = S_EMPTY;
    end
  end

  always_comb begin
    byte_sel = rdata_q[7:0];
    case (addr_lo_q)
      2'd1:    byte_sel = rdata_q[15:8];
      2'd2:    byte_sel = rdata_q[23:16];
      2'd3:    byte_sel = rdata_q[31:24];
      default: byte_sel = rdata_q[7:0];
    endcase
  end

  assign half_sel = addr_lo_q[1] ? rdata_q[31:16] : rdata_q[15:0];

  always_comb begin
    wdata_dec = result_q;
    strb_dec  = 4'b1111;
    case (load_op_q)
      3'd1: wdata_dec = {{24{byte_sel[7]}}, byte_sel};
      3'd2: wdata_dec = {24'b0, byte_sel};
      3'd3: wdata_dec = {{16{half_sel[15]}}, half_sel};
      3'd4: wdata_dec = {16'b0, half_sel};
      3'd5: wdata_dec = rdata_q;
      3'd6: begin
        case (addr_lo_q)
          2'd0:    begin wdata_dec = {rdata_q[7:0], 24'b0};  strb_dec = 4'b1000; end
          2'd1:    begin wdata_dec = {rdata_q[15:0], 16'b0}; strb_dec = 4'b1100; end
          2'd2:    begin wdata_dec = {rdata_q[23:0], 8'b0};  strb_dec = 4'b1110; end
          default: begin wdata_dec = rdata_q;                strb_dec = 4'b1111; end
        endcase
      end
      3'd7: begin
        case (addr_lo_q)
          2'd0:    begin wdata_dec = rdata_q;                 strb_dec = 4'b1111; end
          2'd1:    begin wdata_dec = {8'b0, rdata_q[31:8]};   strb_dec = 4'b0111; end
          2'd2:    begin wdata_dec = {16'b0, rdata_q[31:16]}; strb_dec = 4'b0011; end
          default: begin wdata_dec = {24'b0, rdata_q[31:24]}; strb_dec = 4'b0001; end
        endcase
      end
      default: wdata_dec = result_q;
    endcase
  end

  assign rf_wen           = (state_q == S_READY) && gr_we_q && (dest_q != 5'd0);
  assign rf_waddr         = dest_q;
  assign rf_wdata         = wdata_dec;
  assign rf_strb          = (state_q == S_READY) ? strb_dec : 4'b0000;
  assign ws_pending       = (state_q == S_WAIT);
  assign ws_dest          = ((state_q != S_EMPTY) && gr_we_q) ? dest_q : 5'd0;
  assign debug_wb_pc      = pc_q;
  assign debug_wb_rf_wen  = rf_wen ? rf_strb : 4'b0000;
  assign debug_wb_rf_wnum = dest_q;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed scenarios plus random traffic, compared each cycle
// against an occupancy/data model of the write-back slot.
module tb_wb_stage;

  logic        clk;
  logic        resetn;
  logic        ms_to_ws_valid;
  logic        ws_allowin;
  logic [31:0] ms_pc;
  logic [4:0]  ms_dest;
  logic        ms_gr_we;
  logic        ms_need_data;
  logic [2:0]  ms_load_op;
  logic [1:0]  ms_addr_lo;
  logic [31:0] ms_result;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [3:0]  rf_strb;
  logic [4:0]  ws_dest;
  logic        ws_pending;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;

  wb_stage dut (
    .clk              (clk),
    .resetn           (resetn),
    .ms_to_ws_valid   (ms_to_ws_valid),
    .ws_allowin       (ws_allowin),
    .ms_pc            (ms_pc),
    .ms_dest          (ms_dest),
    .ms_gr_we         (ms_gr_we),
    .ms_need_data     (ms_need_data),
    .ms_load_op       (ms_load_op),
    .ms_addr_lo       (ms_addr_lo),
    .ms_result        (ms_result),
    .data_data_ok     (data_data_ok),
    .data_rdata       (data_rdata),
    .rf_wen           (rf_wen),
    .rf_waddr         (rf_waddr),
    .rf_wdata         (rf_wdata),
    .rf_strb          (rf_strb),
    .ws_dest          (ws_dest),
    .ws_pending       (ws_pending),
    .debug_wb_pc      (debug_wb_pc),
    .debug_wb_rf_wen  (debug_wb_rf_wen),
    .debug_wb_rf_wnum (debug_wb_rf_wnum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // model of the slot: is something held, has its data arrived, and what it is
  bit          m_occ;
  bit          m_have;
  logic [31:0] m_pc;
  logic [4:0]  m_dest;
  logic        m_we;
  logic [2:0]  m_op;
  logic [1:0]  m_lo;
  logic [31:0] m_res;
  logic [31:0] m_data;
  int          wen_pulses;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void ref_write(input logic [2:0] op, input logic [1:0] lo,
                                    input logic [31:0] d, input logic [31:0] r,
                                    output logic [31:0] w, output logic [3:0] s);
    int unsigned b;
    int unsigned h;
    int          k;
    k = int'(lo);
    b = (d >> (8 * k)) & 32'hFF;
    h = (d >> (16 * (k / 2))) & 32'hFFFF;
    s = 4'hF;
    case (op)
      3'd0: w = r;
      3'd1: w = (b >= 128) ? 32'(int'(b) - 256) : b;
      3'd2: w = b;
      3'd3: w = (h >= 32768) ? 32'(int'(h) - 65536) : h;
      3'd4: w = h;
      3'd5: w = d;
      3'd6: begin w = d << (8 * (3 - k)); s = 4'(15 << (3 - k)); end
      default: begin w = d >> (8 * k); s = 4'(15 >> k); end
    endcase
  endfunction

  task automatic model_reset();
    m_occ = 0; m_have = 0;
  endtask

  task automatic check_outputs();
    logic [31:0] w;
    logic [3:0]  s;
    bit          exp_wen;
    exp_wen = m_occ && m_have && m_we && (m_dest != 0);
    check_eq("allowin", ws_allowin, (!m_occ || m_have));
    check_eq("pending", ws_pending, (m_occ && !m_have));
    check_eq("ws_dest", ws_dest, (m_occ && m_we) ? m_dest : 5'd0);
    check_eq("rf_wen", rf_wen, exp_wen);
    if (m_occ) begin
      check_eq("dbg_pc", debug_wb_pc, m_pc);
      check_eq("dbg_wnum", debug_wb_rf_wnum, m_dest);
    end
    if (exp_wen) begin
      ref_write(m_op, m_lo, m_data, m_res, w, s);
      check_eq("waddr", rf_waddr, m_dest);
      check_eq("wdata", rf_wdata, w);
      check_eq("strb", rf_strb, s);
      check_eq("dbg_wen", debug_wb_rf_wen, s);
      wen_pulses++;
    end else begin
      check_eq("dbg_wen_off", debug_wb_rf_wen, 4'b0000);
    end
  endtask

  task automatic model_update();
    if (!resetn) begin
      model_reset();
    end else if (m_occ && !m_have) begin
      if (data_data_ok) begin m_data = data_rdata; m_have = 1; end
    end else if (ms_to_ws_valid) begin
      m_occ = 1;
      m_pc = ms_pc; m_dest = ms_dest; m_we = ms_gr_we;
      m_op = ms_load_op; m_lo = ms_addr_lo; m_res = ms_result;
      if (ms_need_data) begin
        m_have = data_data_ok;
        if (data_data_ok) m_data = data_rdata;
      end else begin
        m_have = 1;
      end
    end else if (m_occ) begin
      m_occ = 0;
    end
  endtask

  // one cycle: outputs checked on the falling edge, model advanced on the rising edge
  task automatic tick();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_instr(input logic v, input logic [31:0] pc, input logic [4:0] dst,
                           input logic we, input logic [2:0] op, input logic [1:0] lo,
                           input logic [31:0] res);
    ms_to_ws_valid = v; ms_pc = pc; ms_dest = dst; ms_gr_we = we;
    ms_load_op = op; ms_need_data = (op != 3'd0); ms_addr_lo = lo; ms_result = res;
  endtask

  task automatic async_reset_check();
    #2 resetn = 1'b0;
    model_reset();
    #1;
    check_eq("rst_allowin", ws_allowin, 1'b1);
    check_eq("rst_wen", rf_wen, 1'b0);
    check_eq("rst_strb", rf_strb, 4'b0000);
    check_eq("rst_dest", ws_dest, 5'd0);
    check_eq("rst_pending", ws_pending, 1'b0);
    check_eq("rst_dbg_wen", debug_wb_rf_wen, 4'b0000);
  endtask

  initial begin
    resetn = 1'b0;
    set_instr(0, 0, 0, 0, 0, 0, 0);
    data_data_ok = 0; data_rdata = 0;
    model_reset();
    wen_pulses = 0;
    #3;
    check_eq("rst_allowin", ws_allowin, 1'b1);
    check_eq("rst_wen", rf_wen, 1'b0);
    check_eq("rst_strb", rf_strb, 4'b0000);
    check_eq("rst_pending", ws_pending, 1'b0);
    check_eq("rst_dbg_wen", debug_wb_rf_wen, 4'b0000);
    @(posedge clk); #1;
    resetn = 1'b1;
    tick();

    // ALU op
    set_instr(1, 32'hBFC00000, 5'd3, 1, 3'd0, 2'd0, 32'h1234);
    tick();
    set_instr(0, 0, 0, 0, 0, 0, 0);
    check_eq("alu_wen", rf_wen, 1'b1);
    check_eq("alu_waddr", rf_waddr, 5'd3);
    check_eq("alu_wdata", rf_wdata, 32'h00001234);
    check_eq("alu_strb", rf_strb, 4'b1111);
    tick();
    check_eq("alu_empty_dest", ws_dest, 5'd0);

    // LB with response three cycles after entry
    set_instr(1, 32'h100, 5'd7, 1, 3'd1, 2'd2, 32'h0);
    tick();
    set_instr(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      check_eq("lb_pending", ws_pending, 1'b1);
      check_eq("lb_allowin", ws_allowin, 1'b0);
      check_eq("lb_no_wen", rf_wen, 1'b0);
      data_data_ok = (i == 2); data_rdata = (i == 2) ? 32'h11F02233 : 32'h0;
      tick();
    end
    data_data_ok = 0;
    check_eq("lb_wdata", rf_wdata, 32'hFFFFFFF0);
    check_eq("lb_strb", rf_strb, 4'b1111);
    tick();

    // LWL / LWR with data on the entry edge
    set_instr(1, 32'h200, 5'd9, 1, 3'd6, 2'd1, 32'h0);
    data_data_ok = 1; data_rdata = 32'hAABBCCDD;
    tick();
    set_instr(1, 32'h204, 5'd10, 1, 3'd7, 2'd1, 32'h0);
    check_eq("lwl_wdata", rf_wdata, 32'hCCDD0000);
    check_eq("lwl_strb", rf_strb, 4'b1100);
    check_eq("lwl_dbg_wen", debug_wb_rf_wen, 4'b1100);
    tick();
    set_instr(0, 0, 0, 0, 0, 0, 0);
    data_data_ok = 0;
    check_eq("lwr_wdata", rf_wdata, 32'h00AABBCC);
    check_eq("lwr_strb", rf_strb, 4'b0111);
    tick();

    // four back-to-back ALU ops
    for (int i = 0; i < 4; i++) begin
      set_instr(1, 32'h300 + 4 * i, 5'(i + 1), 1, 3'd0, 2'd0, 32'(i * 17));
      tick();
      check_eq("b2b_wen", rf_wen, 1'b1);
      check_eq("b2b_waddr", rf_waddr, 5'(i + 1));
    end
    set_instr(0, 0, 0, 0, 0, 0, 0);
    tick();

    // dest 0 and stray response while empty
    set_instr(1, 32'h400, 5'd0, 1, 3'd0, 2'd0, 32'hFFFF);
    tick();
    set_instr(0, 0, 0, 0, 0, 0, 0);
    check_eq("d0_wen", rf_wen, 1'b0);
    check_eq("d0_dbg_wen", debug_wb_rf_wen, 4'b0000);
    tick();
    data_data_ok = 1; data_rdata = 32'h5A5A5A5A;
    tick();
    data_data_ok = 0;
    check_eq("stray_allowin", ws_allowin, 1'b1);
    check_eq("stray_pending", ws_pending, 1'b0);
    check_eq("stray_wen", rf_wen, 1'b0);

    // reset while waiting, response arrives during reset
    set_instr(1, 32'h500, 5'd12, 1, 3'd5, 2'd0, 32'h0);
    tick();
    set_instr(0, 0, 0, 0, 0, 0, 0);
    check_eq("rw_pending", ws_pending, 1'b1);
    async_reset_check();
    data_data_ok = 1; data_rdata = 32'h12345678;
    tick();
    resetn = 1'b1;
    tick();
    data_data_ok = 0;
    check_eq("rw_allowin", ws_allowin, 1'b1);
    check_eq("rw_wen", rf_wen, 1'b0);
    tick();

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      logic [2:0] op;
      op = ($urandom_range(0, 9) < 4) ? 3'd0 : 3'($urandom_range(1, 7));
      set_instr($urandom_range(0, 9) < 7, $urandom, ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                $urandom_range(0, 9) != 0, op, 2'($urandom_range(0, 3)), $urandom);
      data_data_ok = ($urandom_range(0, 9) < 3);
      data_rdata = $urandom;
      if ($urandom_range(0, 249) == 0) begin
        async_reset_check();
        tick();
        resetn = 1'b1;
      end else begin
        tick();
      end
    end
    set_instr(0, 0, 0, 0, 0, 0, 0);
    data_data_ok = 1;
    tick();
    tick();
    check_eq("wen_pulses_seen", (wen_pulses > 200), 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
